// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, default latency and FSM state encoding for mem_backend
package mem_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;
  localparam int LATENCY_DEF = 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-entry posted-write FIFO, oldest entry presented on dout
module wb_fifo #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] ent [2];
  logic rp, wp;
  logic [1:0] cnt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = ent[rp];
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  // pointers and occupancy; reset discards any pending entries
  always_ff @(posedge clock)
    if (!reset_n) begin
      rp <= 1'b0;
      wp <= 1'b0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= !wp;
      if (do_pop) rp <= !rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  // entry storage needs no reset, occupancy decides validity
  always_ff @(posedge clock)
    if (do_push) ent[wp] <= din;
endmodule

// File: rtl/mem_backend.sv
// mem_backend: fixed-latency word memory behind the L1; MEM_BACKEND_WRITE_BUFFER_EN adds posted writes
module mem_backend import mem_pkg::*; #(
  parameter int LATENCY = LATENCY_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);
  localparam logic [3:0] L1 = 4'(LATENCY - 1);
  state_t state;
  logic [3:0] cnt, cnt_nxt;
  logic we_q;
  logic [ADDR_W-1:0] addr_q, wr_addr;
  logic [DATA_W-1:0] wdata_q, wr_data;
  logic [ADDR_W+DATA_W-1:0] head;
  logic xfer, push, drain, full, empty, wr_en;
  logic [DATA_W-1:0] mem [2**ADDR_W];
`ifdef MEM_BACKEND_WRITE_BUFFER_EN
  assign push = xfer && req_we;
  assign drain = !empty && cnt == '0;
  wb_fifo #(.W(ADDR_W + DATA_W)) u_wb (
    .clock(clock),
    .reset_n(reset_n),
    .push(push),
    .pop(drain),
    .din({req_addr, req_wdata}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
`else
  assign push = 1'b0;
  assign drain = 1'b0;
  assign full = 1'b0;
  assign empty = 1'b1;
  assign head = '0;
`endif
  assign req_ready = state == IDLE && (req_we ? !full : empty);
  assign xfer = req_valid && req_ready;
  assign busy = state != IDLE || !empty;
  assign wr_en = drain || (state == WAIT && cnt == '0 && we_q);
  assign wr_addr = drain ? head[ADDR_W+DATA_W-1:DATA_W] : addr_q;
  assign wr_data = drain ? head[DATA_W-1:0] : wdata_q;
  for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_word
    logic [DATA_W-1:0] word = DATA_W'(g);
    // one array word, power-up value is its own address, untouched by reset
    always_ff @(posedge clock)
      if (wr_en && wr_addr == ADDR_W'(g)) word <= wr_data;
    assign mem[g] = word;
  end
  // shared latency counter: request WAIT countdown, or background drain of the posted-write head
  always_comb
    cnt_nxt = (state == IDLE && xfer && !push) ? L1 :
              (state == WAIT && cnt != '0) ? cnt - 4'd1 :
              drain ? ((full || push) ? L1 : '0) :
              (push && empty) ? L1 :
              !empty ? cnt - 4'd1 : cnt;
  // request FSM with registered response outputs
  always_ff @(posedge clock)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        IDLE: if (xfer) begin
          state <= push ? RESP : WAIT;
          resp_valid <= push;
          we_q <= req_we;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
        end
        WAIT: if (cnt == '0) begin
          state <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? '0 : mem[addr_q];
        end
        default: begin
          state <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
        end
      endcase
    end
endmodule

// File: doc/mem_backend.md
MEM_BACKEND -- requirements
Module: mem_backend

Interface
REQ-001 Parameter LATENCY, default 3, memory-array access cycles; legal 1..15.
REQ-002 Parameter ADDR_W, default 8, word address width (matches the 8-bit L1 tag).
REQ-003 Parameter DATA_W, default 4, word width (matches the L1 data field).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 req_valid  input  1  L1 miss-fill or write-back request present.
REQ-007 req_ready  output  1  block accepts the request this cycle.
REQ-008 req_we  input  1  1 = write-back of dirty victim, 0 = line fill read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-013 busy  output  1  request in flight or write buffer non-empty.

Function
REQ-014 Storage SHALL be a 2^ADDR_W x DATA_W array initialised to mem[a] = a[DATA_W-1:0] at power-up, not altered by reset.
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 Transfer SHALL occur on an edge where req_valid and req_ready are both 1; addr/we/wdata latched then.
REQ-017 req_ready SHALL be 1 only in IDLE (subject to REQ-030); request inputs ignored otherwise.
REQ-018 IDLE -> WAIT on transfer; 4-bit counter loaded with LATENCY-1.
REQ-019 WAIT SHALL decrement the counter each cycle; at 0, the array read or write is performed and state -> RESP.
REQ-020 RESP SHALL assert resp_valid for exactly one cycle, then -> IDLE.
REQ-021 Timing: transfer in cycle 0 -> resp_valid in cycle LATENCY+1; next transfer earliest cycle LATENCY+2.
REQ-022 resp_rdata SHALL hold the read data only while resp_valid=1 and 0 otherwise.
REQ-023 Write SHALL update the array once, in the last WAIT cycle; a read issued after its response sees the new value.
REQ-024 req_valid SHALL not be required to stay high after a transfer; deasserting it mid-WAIT has no effect.
REQ-025 busy SHALL be 1 in WAIT and RESP, and whenever the write buffer is non-empty.

Reset
REQ-026 reset_n=0 at an edge SHALL force IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, busy 0.
REQ-027 Reset during WAIT SHALL abandon the request; its write SHALL NOT reach the array and no response is produced.
REQ-028 Reset SHALL flush the write buffer; pending writes are discarded.

Configuration
REQ-029 Macro MEM_BACKEND_WRITE_BUFFER_EN SHALL compile in a 2-entry posted-write FIFO; absent, all writes follow REQ-016..REQ-023.
REQ-030 With it: writes are accepted in IDLE when the FIFO is not full; resp_valid follows next cycle.
REQ-031 With it: the FIFO drains in background, oldest first, LATENCY cycles per entry, through the same WAIT counter.
REQ-032 With it: req_ready SHALL be 0 for reads while the FIFO is non-empty, so reads never bypass pending writes.
REQ-033 With it: req_ready SHALL be 0 for writes while the FIFO is full.

Structure
REQ-034 Package mem_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum (IDLE, WAIT, RESP) and the default LATENCY.
REQ-035 The write buffer SHALL be sub-module wb_fifo (2 entries, push/pop/full/empty), instantiated only under the macro.

Verification
REQ-036 Reset, LATENCY=3, read 0x65 in cycle 0 -> resp_valid=1, resp_rdata=0x5 in cycle 4 only.
REQ-037 Write 0x65=0xA, then read 0x65 -> write resp_rdata=0x0, read resp_rdata=0xA.
REQ-038 req_valid held high for 10 cycles -> req_ready=0 in cycles 1..4; second transfer in cycle 5.
REQ-039 Write 0x10=0xF, reset_n=0 in cycle 2, then read 0x10 -> resp_rdata=0x0 and no earlier resp_valid.
REQ-040 LATENCY=1, read 0xFF -> resp_valid in cycle 2, resp_rdata=0xF; LATENCY=15 -> resp_valid in cycle 16.
REQ-041 Macro on: writes 0x01=1, 0x02=2, 0x03=3 back-to-back, then read 0x03:
- first two writes get a response one cycle after acceptance;
- the third write stalls until an entry drains;
- the read is accepted only after the FIFO is empty and returns 0x3.
